// File: rtl/bcd_hex_multi_counter.sv
// N-digit cascaded BCD/hex up/down counter with prescaler, terminal-count enable and wrap flags.
// Optional parallel load (load, load_val) is built when BCD_HEX_MULTI_COUNTER_LOAD_EN is defined.
module bcd_hex_multi_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic                  clkSignal,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  upDown,
    input  logic                  BCDHex,
    input  logic                  clear,
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  enout,
    output logic                  wrap_pulse,
    output logic                  wrapped
);

    localparam int unsigned CW   = 4 * DIGITS;
    localparam int unsigned PW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(STEP_DIV - 1);

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              wrapped_q, wrapped_d;
    logic [DIGITS-1:0] term_c;
    logic [DIGITS-1:0] ripple_c;
    logic              all_term_c;
    logic              presc_max_c;
    logic              step_c;

    // Next value of one digit when it steps; illegal BCD digits are folded back into 0..9.
    function automatic logic [3:0] digit_next(input logic [3:0] d, input logic up, input logic hex);
        logic [3:0] r;
        if (up) begin
            if (hex)            r = d + 4'd1;
            else if (d >= 4'd9) r = 4'd0;
            else                r = d + 4'd1;
        end else begin
            if (hex)            r = d - 4'd1;
            else if (d == 4'd0) r = 4'd9;
            else if (d > 4'd9)  r = 4'd9;
            else                r = d - 4'd1;
        end
        return r;
    endfunction

    // Per-digit terminal detection for the current direction and mode.
    always_comb begin
        term_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!upDown)     term_c[i] = (count_q[4*i +: 4] == 4'd0);
            else if (BCDHex) term_c[i] = (count_q[4*i +: 4] == 4'hF);
            else             term_c[i] = (count_q[4*i +: 4] >= 4'd9);
        end
    end

    // Ripple-enable chain: digit i steps only when all lower digits are terminal.
    always_comb begin
        ripple_c   = '0;
        all_term_c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ripple_c[i] = all_term_c;
            all_term_c  = all_term_c & term_c[i];
        end
    end

    assign presc_max_c = (presc_q == PMAX);
    assign step_c      = enable & presc_max_c;
    assign enout       = step_c & all_term_c;

    always_comb begin
        count_d      = count_q;
        presc_d      = presc_q;
        wrap_pulse_d = 1'b0;
        wrapped_d    = wrapped_q;
        if (clear) begin
            count_d   = '0;
            presc_d   = '0;
            wrapped_d = 1'b0;
        end
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
        else if (load) begin
            count_d = load_val;
            presc_d = '0;
        end
`endif
        else if (step_c) begin
            presc_d      = '0;
            wrap_pulse_d = all_term_c;
            wrapped_d    = wrapped_q | all_term_c;
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple_c[i]) count_d[4*i +: 4] = digit_next(count_q[4*i +: 4], upDown, BCDHex);
            end
        end else if (enable) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clkSignal or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            presc_q      <= '0;
            wrap_pulse_q <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            presc_q      <= presc_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_bcd_hex_multi_counter.sv
// Bench for bcd_hex_multi_counter: two instances (STEP_DIV=1 and 3) against an arithmetic reference model.
module tb_bcd_hex_multi_counter;

    logic clkSignal = 1'b0;
    always #5 clkSignal = ~clkSignal;

    logic rst, enable, upDown, BCDHex, clear;
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
    logic        load;
    logic [15:0] load_val;
`endif
    logic [15:0] count1, count3;
    logic        enout1, enout3, wp1, wp3, wr1, wr3;

    int checks   = 0;
    int failures = 0;

    int m_cnt[2];
    int m_presc[2];
    bit m_wp[2];
    bit m_wr[2];
    int sd[2] = '{1, 3};

    bcd_hex_multi_counter #(.DIGITS(4), .STEP_DIV(1)) dut1 (
        .clkSignal(clkSignal), .rst(rst), .enable(enable), .upDown(upDown),
        .BCDHex(BCDHex), .clear(clear),
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count(count1), .enout(enout1), .wrap_pulse(wp1), .wrapped(wr1)
    );

    bcd_hex_multi_counter #(.DIGITS(4), .STEP_DIV(3)) dut3 (
        .clkSignal(clkSignal), .rst(rst), .enable(enable), .upDown(upDown),
        .BCDHex(BCDHex), .clear(clear),
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count(count3), .enout(enout3), .wrap_pulse(wp3), .wrapped(wr3)
    );

    function automatic int dig(input int v, input int i);
        return (v >> (4 * i)) & 15;
    endfunction

    function automatic bit legal_bcd(input int v);
        for (int i = 0; i < 4; i++) if (dig(v, i) > 9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int to_dec(input int v);
        return dig(v, 0) + 10 * dig(v, 1) + 100 * dig(v, 2) + 1000 * dig(v, 3);
    endfunction

    function automatic int to_bcd(input int d);
        return (d % 10) | (((d / 10) % 10) << 4) | (((d / 100) % 10) << 8) | (((d / 1000) % 10) << 12);
    endfunction

    function automatic bit all_term(input int v, input bit up, input bit hex);
        if (!up) return v == 0;
        if (hex) return v == 'hFFFF;
        for (int i = 0; i < 4; i++) if (dig(v, i) < 9) return 1'b0;
        return 1'b1;
    endfunction

    // Legal values use plain modular arithmetic; illegal BCD falls back to digit rules.
    function automatic int next_val(input int v, input bit up, input bit hex);
        int r;
        int d;
        if (hex) return up ? ((v + 1) & 'hFFFF) : ((v - 1) & 'hFFFF);
        if (legal_bcd(v)) return to_bcd(up ? (to_dec(v) + 1) % 10000 : (to_dec(v) + 9999) % 10000);
        r = v;
        for (int i = 0; i < 4; i++) begin
            d = dig(v, i);
            r = r & ~(15 << (4 * i));
            if (up) begin
                if (d >= 9) continue;
                r = r | ((d + 1) << (4 * i));
                break;
            end else begin
                if (d == 0) begin
                    r = r | (9 << (4 * i));
                    continue;
                end
                r = r | (((d > 9) ? 9 : d - 1) << (4 * i));
                break;
            end
        end
        return r;
    endfunction

    function automatic bit exp_enout(input int k);
        return enable && all_term(m_cnt[k], upDown, BCDHex) && (m_presc[k] == sd[k] - 1);
    endfunction

    task automatic model_edge(input int k);
        bit t;
        if (rst || clear) begin
            m_cnt[k] = 0; m_presc[k] = 0; m_wp[k] = 0; m_wr[k] = 0;
        end
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
        else if (load) begin
            m_cnt[k] = int'(load_val); m_presc[k] = 0; m_wp[k] = 0;
        end
`endif
        else if (!enable) begin
            m_wp[k] = 0;
        end else if (m_presc[k] == sd[k] - 1) begin
            t = all_term(m_cnt[k], upDown, BCDHex);
            m_presc[k] = 0;
            m_wp[k] = t;
            if (t) m_wr[k] = 1;
            m_cnt[k] = next_val(m_cnt[k], upDown, BCDHex);
        end else begin
            m_presc[k] = m_presc[k] + 1;
            m_wp[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clkSignal);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_presc[k] = 0; m_wp[k] = 0; m_wr[k] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; upDown = 1'b1; BCDHex = 1'b0; clear = 1'b0;
        #3;
        checks++; if (count1 !== 16'h0000) begin failures++; $display("FAIL reset_count: got %h expected 0000", count1); end
        checks++; if (wr1 !== 1'b0 || wp1 !== 1'b0) begin failures++; $display("FAIL reset_flags: got wr=%b wp=%b expected 0 0", wr1, wp1); end
        model_reset();
        @(negedge clkSignal);
        rst = 1'b0;
        tick();
        enable = 1'b1;
        repeat (357) tick();
        checks++; if (count1 !== 16'h0357) begin failures++; $display("FAIL pre_async_count: got %h expected 0357", count1); end
        #2 rst = 1'b1;
        #1;
        checks++; if (count1 !== 16'h0000 || count3 !== 16'h0000) begin failures++; $display("FAIL async_reset_count: got %h/%h expected 0000/0000", count1, count3); end
        checks++; if (wr1 !== 1'b0 || wp1 !== 1'b0) begin failures++; $display("FAIL async_reset_flags: got wr=%b wp=%b expected 0 0", wr1, wp1); end
        model_reset();
        @(negedge clkSignal);
        rst = 1'b0; enable = 1'b0;
        tick();
    endtask

    task automatic test_bcd_carry();
        logic [15:0] exp_seq [3];
        exp_seq = '{16'h0999, 16'h1000, 16'h1001};
        clear = 1'b1; tick(); clear = 1'b0;
        upDown = 1'b1; BCDHex = 1'b0; enable = 1'b1;
        repeat (998) tick();
        checks++; if (count1 !== 16'h0998) begin failures++; $display("FAIL bcd_start: got %h expected 0998", count1); end
        for (int j = 0; j < 3; j++) begin
            checks++; if (enout1 !== 1'b0) begin failures++; $display("FAIL bcd_carry_enout[%0d]: got %b expected 0", j, enout1); end
            tick();
            checks++; if (count1 !== exp_seq[j]) begin failures++; $display("FAIL bcd_carry_count[%0d]: got %h expected %h", j, count1, exp_seq[j]); end
        end
    endtask

    task automatic test_bcd_wrap();
        repeat (8998) tick();
        checks++; if (count1 !== 16'h9999) begin failures++; $display("FAIL wrap_pre_count: got %h expected 9999", count1); end
        checks++; if (enout1 !== 1'b1) begin failures++; $display("FAIL wrap_enout: got %b expected 1", enout1); end
        tick();
        checks++; if (count1 !== 16'h0000 || wp1 !== 1'b1 || wr1 !== 1'b1) begin failures++; $display("FAIL wrap_edge: got cnt=%h wp=%b wr=%b expected 0000 1 1", count1, wp1, wr1); end
        tick();
        checks++; if (count1 !== 16'h0001 || wp1 !== 1'b0 || wr1 !== 1'b1) begin failures++; $display("FAIL wrap_after: got cnt=%h wp=%b wr=%b expected 0001 0 1", count1, wp1, wr1); end
        enable = 1'b0;
        repeat (3) tick();
        checks++; if (wr1 !== 1'b1 || count1 !== 16'h0001) begin failures++; $display("FAIL wrap_sticky: got cnt=%h wr=%b expected 0001 1", count1, wr1); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if (wr1 !== 1'b0 || count1 !== 16'h0000) begin failures++; $display("FAIL wrap_clear: got cnt=%h wr=%b expected 0000 0", count1, wr1); end
    endtask

    task automatic test_hex_down();
        BCDHex = 1'b1; upDown = 1'b1; enable = 1'b1;
        tick();
        checks++; if (count1 !== 16'h0001) begin failures++; $display("FAIL hex_up1: got %h expected 0001", count1); end
        upDown = 1'b0;
        #1;
        checks++; if (enout1 !== 1'b0) begin failures++; $display("FAIL hex_enout_at1: got %b expected 0", enout1); end
        tick();
        checks++; if (count1 !== 16'h0000 || enout1 !== 1'b1) begin failures++; $display("FAIL hex_down0: got cnt=%h enout=%b expected 0000 1", count1, enout1); end
        tick();
        checks++; if (count1 !== 16'hFFFF || wp1 !== 1'b1) begin failures++; $display("FAIL hex_down_wrap: got cnt=%h wp=%b expected FFFF 1", count1, wp1); end
        clear = 1'b1; tick(); clear = 1'b0;
        upDown = 1'b1;
        repeat (250) tick();
        checks++; if (count1 !== 16'h00FA) begin failures++; $display("FAIL hex_00FA: got %h expected 00FA", count1); end
        BCDHex = 1'b0;
        tick();
        checks++; if (count1 !== 16'h0100) begin failures++; $display("FAIL mode_switch: got %h expected 0100", count1); end
    endtask

    task automatic test_prescale();
        clear = 1'b1; tick(); clear = 1'b0;
        upDown = 1'b1; BCDHex = 1'b0; enable = 1'b1;
        repeat (9) tick();
        checks++; if (count3 !== 16'h0003 || count1 !== 16'h0009) begin failures++; $display("FAIL presc_9: got %h/%h expected 0003/0009", count3, count1); end
        enable = 1'b0;
        repeat (5) tick();
        checks++; if (count3 !== 16'h0003) begin failures++; $display("FAIL presc_hold: got %h expected 0003", count3); end
        enable = 1'b1;
        repeat (2) tick();
        checks++; if (count3 !== 16'h0003) begin failures++; $display("FAIL presc_resume2: got %h expected 0003", count3); end
        tick();
        checks++; if (count3 !== 16'h0004) begin failures++; $display("FAIL presc_resume3: got %h expected 0004", count3); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) upDown = ~upDown;
            if ($urandom_range(0, 15) == 0) BCDHex = ~BCDHex;
            clear = ($urandom_range(0, 49) == 0);
            #1;
            checks++; if (enout1 !== exp_enout(0) || enout3 !== exp_enout(1)) begin failures++; $display("FAIL rand_enout[%0d]: got %b/%b expected %b/%b", n, enout1, enout3, exp_enout(0), exp_enout(1)); end
            tick();
            checks++;
            if (count1 !== 16'(m_cnt[0]) || wp1 !== m_wp[0] || wr1 !== m_wr[0] ||
                count3 !== 16'(m_cnt[1]) || wp3 !== m_wp[1] || wr3 !== m_wr[1]) begin
                failures++;
                $display("FAIL rand_state[%0d]: got %h %b %b / %h %b %b expected %h %b %b / %h %b %b", n,
                         count1, wp1, wr1, count3, wp3, wr3,
                         16'(m_cnt[0]), m_wp[0], m_wr[0], 16'(m_cnt[1]), m_wp[1], m_wr[1]);
            end
        end
        clear = 1'b0;
    endtask

`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
    task automatic test_load();
        enable = 1'b0; load = 1'b1; load_val = 16'h1234;
        tick();
        checks++; if (count1 !== 16'h1234 || count3 !== 16'h1234) begin failures++; $display("FAIL load: got %h/%h expected 1234", count1, count3); end
        clear = 1'b1;
        tick();
        checks++; if (count1 !== 16'h0000) begin failures++; $display("FAIL load_vs_clear: got %h expected 0000", count1); end
        clear = 1'b0; load = 1'b0;
    endtask
`endif

    initial begin
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
        load = 1'b0; load_val = 16'h0000;
`endif
        test_reset();
        test_bcd_carry();
        test_bcd_wrap();
        test_hex_down();
        test_prescale();
`ifdef BCD_HEX_MULTI_COUNTER_LOAD_EN
        test_load();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
